adder_lut_writer: RTL and testbench

- Runtime-writable replacement for the fixed 256x5 adder lookup table: the writer side of the LUT.
- Holds two banks of 256x5 distributed RAM:
  - The active bank serves asynchronous lookups to the trigger datapath.
  - The shadow bank is loaded through a valid/ready write port.
- A commit request swaps the banks atomically, then copies the new active bank into the new shadow bank so that incremental edits start from the live contents.
- Sits between the configuration/register interface and the adder datapath.

---
 rtl/adder_lut_writer_if.sv | 32 +++
 rtl/adder_lut_writer.sv | 176 +++++++++++++++++
 tb/tb_adder_lut_writer.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_lut_writer_if.sv
// Write/commit/lookup bundle between the configuration side and the LUT writer.
interface adder_lut_writer_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 5,
    parameter int unsigned CNT_W  = 9
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              commit_req;
    logic              commit_ack;
    logic              busy;
    logic              active_bank;
    logic [CNT_W-1:0]  wr_count;
    logic [ADDR_W-1:0] lut_addr;
    logic [DATA_W-1:0] lut_data;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] rb_data;

    // Configuration / datapath side
    modport master (
        output wr_valid, wr_addr, wr_data, commit_req, lut_addr, rb_addr,
        input  wr_ready, commit_ack, busy, active_bank, wr_count, lut_data, rb_data
    );

    // LUT writer side
    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req, lut_addr, rb_addr,
        output wr_ready, commit_ack, busy, active_bank, wr_count, lut_data, rb_data
    );
endinterface

// File: rtl/adder_lut_writer.sv
// Double-banked runtime-writable adder LUT: active bank serves lookups,
// shadow bank takes writes, commit swaps banks and re-syncs the shadow.
module adder_lut_writer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 5,
    parameter int unsigned CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    adder_lut_writer_if.slave bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWAP  = 2'd2,
        ST_COPY  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_pending;
    logic              w_pending_nxt;
    logic              r_active;
    logic              w_active_nxt;
    logic [CNT_W-1:0]  r_wr_count;
    logic [CNT_W-1:0]  w_wr_count_nxt;
    logic              r_commit_ack;
    logic              w_commit_ack_nxt;
    logic              r_wr_ready;
    logic              r_busy;
    logic [DATA_W-1:0] r_rb_data;

    logic [DATA_W-1:0] r_bank0 [DEPTH];
    logic [DATA_W-1:0] r_bank1 [DEPTH];

    logic              w_fire;
    logic              w_last;
    logic              w_we0;
    logic              w_we1;
    logic [ADDR_W-1:0] w_cnt_lo;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_copy_src;
    logic [DATA_W-1:0] w_lut_raw;
    logic [DATA_W-1:0] w_rb_src;

    assign w_cnt_lo   = r_cnt[ADDR_W-1:0];
    assign w_last     = (w_cnt_lo == {ADDR_W{1'b1}});
    assign w_fire     = bus.wr_valid && r_wr_ready;

    // During COPY r_active already names the new active bank
    assign w_copy_src = r_active ? r_bank1[w_cnt_lo] : r_bank0[w_cnt_lo];
    assign w_lut_raw  = r_active ? r_bank1[bus.lut_addr] : r_bank0[bus.lut_addr];
    assign w_rb_src   = r_active ? r_bank0[bus.rb_addr] : r_bank1[bus.rb_addr];

    // Lookup path is combinational; masked while banks are being cleared
    assign bus.lut_data    = (r_state == ST_CLEAR) ? '0 : w_lut_raw;
    assign bus.wr_ready    = r_wr_ready;
    assign bus.busy        = r_busy;
    assign bus.commit_ack  = r_commit_ack;
    assign bus.active_bank = r_active;
    assign bus.wr_count    = r_wr_count;
    assign bus.rb_data     = r_rb_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and RAM write-port decode
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pending_nxt    = r_pending | bus.commit_req;
        w_active_nxt     = r_active;
        w_wr_count_nxt   = r_wr_count;
        w_commit_ack_nxt = 1'b0;
        w_we0            = 1'b0;
        w_we1            = 1'b0;
        w_waddr          = w_cnt_lo;
        w_wdata          = '0;

        case (r_state)
            ST_CLEAR: begin
                w_we0     = 1'b1;
                w_we1     = 1'b1;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_fire) begin
                    w_waddr = bus.wr_addr;
                    w_wdata = bus.wr_data;
                    w_we0   = r_active;
                    w_we1   = ~r_active;
                    if (r_wr_count != {CNT_W{1'b1}}) begin
                        w_wr_count_nxt = r_wr_count + CNT_W'(1);
                    end
                end
                if (bus.commit_req || r_pending) begin
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_active_nxt   = ~r_active;
                w_wr_count_nxt = '0;
                w_cnt_nxt      = '0;
                w_state_nxt    = ST_COPY;
            end
            ST_COPY: begin
                // cnt[ADDR_W] marks the single acknowledge cycle after the last copy
                if (!r_cnt[ADDR_W]) begin
                    w_wdata   = w_copy_src;
                    w_we0     = r_active;
                    w_we1     = ~r_active;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (w_last) begin
                        w_commit_ack_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Control registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_active     <= 1'b0;
            r_wr_count   <= '0;
            r_commit_ack <= 1'b0;
            r_wr_ready   <= 1'b0;
            r_busy       <= 1'b1;
            r_rb_data    <= '0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_pending    <= w_pending_nxt;
            r_active     <= w_active_nxt;
            r_wr_count   <= w_wr_count_nxt;
            r_commit_ack <= w_commit_ack_nxt;
            r_wr_ready   <= (w_state_nxt == ST_LOAD);
            r_busy       <= (w_state_nxt != ST_LOAD);
            r_rb_data    <= (r_state == ST_CLEAR) ? '0 : w_rb_src;
        end
    end

    // Bank storage; contents initialised by the CLEAR sweep, not by reset
    always_ff @(posedge clk) begin
        if (w_we0) begin
            r_bank0[w_waddr] <= w_wdata;
        end
        if (w_we1) begin
            r_bank1[w_waddr] <= w_wdata;
        end
    end
endmodule

// File: tb/tb_adder_lut_writer.sv
// Randomised self-checking bench for adder_lut_writer against a bank-level model.
module tb_adder_lut_writer;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 5;
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned DEPTH   = 256;
    localparam int          CNT_MAX = 511;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_lut_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    adder_lut_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: two banks, which one is live, and the write counter
    logic [DATA_W-1:0] m_bank [2][DEPTH];
    int m_active;
    int m_count;

    // Event monitor for acknowledge pulses and bank swaps
    int   ack_total   = 0;
    int   toggles     = 0;
    logic prev_active = 1'b0;
    always @(negedge clk) begin
        if (bus.commit_ack === 1'b1) ack_total++;
        if (bus.active_bank !== prev_active) toggles++;
        prev_active = bus.active_bank;
    end

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_bank[0][i] = '0;
            m_bank[1][i] = '0;
        end
        m_active = 0;
        m_count  = 0;
    endfunction

    function automatic void m_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        m_bank[1-m_active][a] = d;
        if (m_count < CNT_MAX) m_count++;
    endfunction

    function automatic void m_commit();
        m_active = 1 - m_active;
        for (int i = 0; i < DEPTH; i++) m_bank[1-m_active][i] = m_bank[m_active][i];
        m_count = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a write request until accepted (bounded) and records it in the model
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic ok;
        ok = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        for (int i = 0; i < 600 && !ok; i++) begin
            ok = (bus.wr_ready === 1'b1);
            tick();
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_handshake addr=%0h got=timeout exp=accepted", a);
        end else begin
            m_write(a, d);
        end
    endtask

    // Waits (bounded) for commit_ack, then one more cycle so LOAD is reached
    task automatic wait_ack(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = (bus.commit_ack === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_ack got=timeout exp=commit_ack", name);
        end
        tick();
    endtask

    task automatic test_reset();
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.commit_req = 1'b0; bus.lut_addr = '0; bus.rb_addr = '0;
        rst = 1'b1;
        m_reset();
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.commit_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b rdy=%b ack=%b exp busy=1 rdy=0 ack=0",
                     bus.busy, bus.wr_ready, bus.commit_ack);
        end
        checks++;
        if (bus.wr_count !== '0 || bus.active_bank !== 1'b0 || bus.rb_data !== '0) begin
            errors++;
            $display("FAIL reset_data got cnt=%0d ab=%b rb=%0h exp 0 0 0",
                     bus.wr_count, bus.active_bank, bus.rb_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_busy cycle=%0d got busy=%b rdy=%b exp busy=1 rdy=0",
                         i, bus.busy, bus.wr_ready);
            end
            tick();
        end
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done got rdy=%b busy=%b exp rdy=1 busy=0", bus.wr_ready, bus.busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus.lut_addr = ADDR_W'(i);
            #1;
            checks++;
            if (bus.lut_data !== m_bank[m_active][i]) begin
                errors++;
                $display("FAIL clear_lut addr=%0h got=%0h exp=%0h", i, bus.lut_data, m_bank[m_active][i]);
            end
        end
        checks++;
        if (bus.wr_count !== CNT_W'(m_count)) begin
            errors++;
            $display("FAIL clear_wr_count got=%0d exp=%0d", bus.wr_count, m_count);
        end
    endtask

    task automatic test_write();
        logic [ADDR_W-1:0] a;
        tick();
        do_write(8'h37, 5'h15);
        bus.lut_addr = 8'h37;
        bus.rb_addr  = 8'h37;
        #1;
        checks++;
        if (bus.lut_data !== m_bank[m_active][8'h37]) begin
            errors++;
            $display("FAIL write_not_live got=%0h exp=%0h", bus.lut_data, m_bank[m_active][8'h37]);
        end
        tick();
        checks++;
        if (bus.rb_data !== m_bank[1-m_active][8'h37]) begin
            errors++;
            $display("FAIL write_readback got=%0h exp=%0h", bus.rb_data, m_bank[1-m_active][8'h37]);
        end
        checks++;
        if (bus.wr_count !== CNT_W'(m_count)) begin
            errors++;
            $display("FAIL write_count got=%0d exp=%0d", bus.wr_count, m_count);
        end
        for (int i = 0; i < 24; i++) do_write(ADDR_W'($urandom()), DATA_W'($urandom()));
        for (int i = 0; i < 16; i++) begin
            a = ADDR_W'($urandom());
            bus.rb_addr  = a;
            bus.lut_addr = a;
            #1;
            checks++;
            if (bus.lut_data !== m_bank[m_active][a]) begin
                errors++;
                $display("FAIL write_rand_lut addr=%0h got=%0h exp=%0h", a, bus.lut_data, m_bank[m_active][a]);
            end
            tick();
            checks++;
            if (bus.rb_data !== m_bank[1-m_active][a]) begin
                errors++;
                $display("FAIL write_rand_rb addr=%0h got=%0h exp=%0h", a, bus.rb_data, m_bank[1-m_active][a]);
            end
        end
    endtask

    task automatic test_commit();
        logic [DATA_W-1:0] old_v;
        logic [DATA_W-1:0] new_v;
        logic              rdy_at_ack;
        logic [ADDR_W-1:0] a;
        int                ack_at;
        old_v  = m_bank[m_active][8'h37];
        new_v  = m_bank[1-m_active][8'h37];
        ack_at = -1;
        rdy_at_ack = 1'bx;
        bus.lut_addr   = 8'h37;
        bus.commit_req = 1'b1;
        #1;
        checks++;
        if (bus.lut_data !== old_v) begin
            errors++;
            $display("FAIL commit_c0_lut got=%0h exp=%0h", bus.lut_data, old_v);
        end
        tick();
        bus.commit_req = 1'b0;
        checks++;
        if (bus.active_bank !== 1'(m_active) || bus.lut_data !== old_v) begin
            errors++;
            $display("FAIL commit_c1 got ab=%b lut=%0h exp ab=%0d lut=%0h",
                     bus.active_bank, bus.lut_data, m_active, old_v);
        end
        m_commit();
        tick();
        checks++;
        if (bus.active_bank !== 1'(m_active) || bus.lut_data !== new_v) begin
            errors++;
            $display("FAIL commit_c2 got ab=%b lut=%0h exp ab=%0d lut=%0h",
                     bus.active_bank, bus.lut_data, m_active, new_v);
        end
        for (int k = 3; k <= 400 && ack_at < 0; k++) begin
            tick();
            if (bus.commit_ack === 1'b1) begin
                ack_at     = k;
                rdy_at_ack = bus.wr_ready;
            end
        end
        checks++;
        if (ack_at != 258) begin
            errors++;
            $display("FAIL commit_ack_latency got=%0d exp=258", ack_at);
        end
        checks++;
        if (rdy_at_ack !== 1'b0) begin
            errors++;
            $display("FAIL commit_rdy_during_ack got=%b exp=0", rdy_at_ack);
        end
        tick();
        checks++;
        if (bus.commit_ack !== 1'b0 || bus.wr_ready !== 1'b1 || bus.wr_count !== CNT_W'(m_count)) begin
            errors++;
            $display("FAIL commit_after got ack=%b rdy=%b cnt=%0d exp ack=0 rdy=1 cnt=%0d",
                     bus.commit_ack, bus.wr_ready, bus.wr_count, m_count);
        end
        bus.rb_addr = 8'h37;
        tick();
        checks++;
        if (bus.rb_data !== m_bank[1-m_active][8'h37]) begin
            errors++;
            $display("FAIL commit_copy_rb got=%0h exp=%0h", bus.rb_data, m_bank[1-m_active][8'h37]);
        end
        for (int i = 0; i < 12; i++) begin
            a = ADDR_W'($urandom());
            bus.lut_addr = a;
            bus.rb_addr  = a;
            tick();
            checks++;
            if (bus.lut_data !== m_bank[m_active][a] || bus.rb_data !== m_bank[1-m_active][a]) begin
                errors++;
                $display("FAIL commit_rand addr=%0h got lut=%0h rb=%0h exp lut=%0h rb=%0h",
                         a, bus.lut_data, bus.rb_data, m_bank[m_active][a], m_bank[1-m_active][a]);
            end
        end
    endtask

    task automatic test_write_commit_same_cycle();
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_ready got=%b exp=1", bus.wr_ready);
        end
        bus.wr_valid = 1'b1; bus.wr_addr = 8'hFF; bus.wr_data = 5'h1F;
        bus.commit_req = 1'b1;
        tick();
        bus.wr_valid = 1'b0; bus.commit_req = 1'b0;
        m_write(8'hFF, 5'h1F);
        m_commit();
        wait_ack("same_cycle");
        bus.lut_addr = 8'hFF;
        bus.rb_addr  = 8'hFF;
        tick();
        checks++;
        if (bus.active_bank !== 1'(m_active) || bus.lut_data !== m_bank[m_active][8'hFF]) begin
            errors++;
            $display("FAIL same_cycle_lut got ab=%b lut=%0h exp ab=%0d lut=%0h",
                     bus.active_bank, bus.lut_data, m_active, m_bank[m_active][8'hFF]);
        end
        checks++;
        if (bus.rb_data !== m_bank[1-m_active][8'hFF] || bus.wr_count !== CNT_W'(m_count)) begin
            errors++;
            $display("FAIL same_cycle_rb got rb=%0h cnt=%0d exp rb=%0h cnt=%0d",
                     bus.rb_data, bus.wr_count, m_bank[1-m_active][8'hFF], m_count);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int t0;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 8; i++) do_write(ADDR_W'($urandom()), DATA_W'($urandom()));
        a0 = ack_total;
        t0 = toggles;
        bus.commit_req = 1'b1; tick(); bus.commit_req = 1'b0;
        m_commit();
        repeat (20) tick();
        bus.commit_req = 1'b1; tick(); bus.commit_req = 1'b0;
        repeat (30) tick();
        bus.commit_req = 1'b1; tick(); bus.commit_req = 1'b0;
        m_commit();
        for (int i = 0; i < 800; i++) begin
            tick();
            if (ack_total - a0 >= 2 && bus.wr_ready === 1'b1) break;
        end
        repeat (300) tick();
        checks++;
        if (ack_total - a0 != 2) begin
            errors++;
            $display("FAIL b2b_acks got=%0d exp=2", ack_total - a0);
        end
        checks++;
        if (toggles - t0 != 2 || bus.active_bank !== 1'(m_active)) begin
            errors++;
            $display("FAIL b2b_swaps got toggles=%0d ab=%b exp toggles=2 ab=%0d",
                     toggles - t0, bus.active_bank, m_active);
        end
        for (int i = 0; i < 12; i++) begin
            a = ADDR_W'($urandom());
            bus.lut_addr = a;
            #1;
            checks++;
            if (bus.lut_data !== m_bank[m_active][a]) begin
                errors++;
                $display("FAIL b2b_lut addr=%0h got=%0h exp=%0h", a, bus.lut_data, m_bank[m_active][a]);
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [ADDR_W-1:0] a;
        for (int n = 1; n <= 600; n++) begin
            do_write(ADDR_W'($urandom()), DATA_W'($urandom()));
            if (n == 300) begin
                checks++;
                if (bus.wr_count !== CNT_W'(m_count)) begin
                    errors++;
                    $display("FAIL sat_mid got=%0d exp=%0d", bus.wr_count, m_count);
                end
            end
        end
        checks++;
        if (bus.wr_count !== CNT_W'(m_count)) begin
            errors++;
            $display("FAIL sat_final got=%0d exp=%0d", bus.wr_count, m_count);
        end
        for (int i = 0; i < 12; i++) begin
            a = ADDR_W'($urandom());
            bus.lut_addr = a;
            bus.rb_addr  = a;
            tick();
            checks++;
            if (bus.lut_data !== m_bank[m_active][a] || bus.rb_data !== m_bank[1-m_active][a]) begin
                errors++;
                $display("FAIL sat_rand addr=%0h got lut=%0h rb=%0h exp lut=%0h rb=%0h",
                         a, bus.lut_data, bus.rb_data, m_bank[m_active][a], m_bank[1-m_active][a]);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        logic [ADDR_W-1:0] wa;
        int a0;
        logic rdy;
        wa = ADDR_W'($urandom());
        do_write(wa, DATA_W'($urandom()) | 5'h01);
        bus.commit_req = 1'b1; tick(); bus.commit_req = 1'b0;
        m_commit();
        repeat (101) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.active_bank !== 1'b0 || bus.commit_ack !== 1'b0) begin
            errors++;
            $display("FAIL midcopy_rst got busy=%b rdy=%b ab=%b ack=%b exp 1 0 0 0",
                     bus.busy, bus.wr_ready, bus.active_bank, bus.commit_ack);
        end
        m_reset();
        a0 = ack_total;
        tick();
        rst = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 300 && !rdy; i++) begin
            tick();
            rdy = (bus.wr_ready === 1'b1);
        end
        checks++;
        if (!rdy || ack_total != a0) begin
            errors++;
            $display("FAIL midcopy_recover got rdy=%b acks=%0d exp rdy=1 acks=0", rdy, ack_total - a0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus.lut_addr = ADDR_W'(i);
            #1;
            checks++;
            if (bus.lut_data !== m_bank[m_active][i]) begin
                errors++;
                $display("FAIL midcopy_lut addr=%0h got=%0h exp=%0h", i, bus.lut_data, m_bank[m_active][i]);
            end
        end
        bus.rb_addr = wa;
        tick();
        checks++;
        if (bus.rb_data !== m_bank[1-m_active][wa] || bus.active_bank !== 1'(m_active) ||
            bus.wr_count !== CNT_W'(m_count)) begin
            errors++;
            $display("FAIL midcopy_state got rb=%0h ab=%b cnt=%0d exp rb=%0h ab=%0d cnt=%0d",
                     bus.rb_data, bus.active_bank, bus.wr_count, m_bank[1-m_active][wa], m_active, m_count);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_commit();
        test_write_commit_same_cycle();
        test_back_to_back();
        test_saturation();
        test_reset_mid_copy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
